dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dmem) between two requesters: port 0 is the processor data port, port 1 is the loader/DMA port.
- Performs one memory beat per clock and arbitrates with sticky round-robin, bounded by a burst limit so neither requester starves.
- Registers read data and returns a one-cycle-delayed acknowledge to the winner.
- Sits between riscv_processor/loader and dmem; MMIO decode stays outside this block.

Parameters:
- MAX_BURST, 4: maximum consecutive beats granted to one port while the other port is requesting; legal range 1..15.
- DMEM_LIMIT, 32'h0000_3000: byte addresses >= this value are out of range.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 beat request.
- m0_we  in  1  port 0 write enable; 0 = read.
- m0_addr  in  32  port 0 byte address.
- m0_wd  in  32  port 0 write data.
- m0_funct3  in  3  port 0 access size/sign code, forwarded to dmem.
- m0_gnt  out  1  port 0 beat accepted this cycle (combinational).
- m0_ack  out  1  one-cycle pulse, the cycle after an accepted beat.
- m0_err  out  1  one-cycle pulse with m0_ack if the beat was out of range.
- m0_rdata  out  32  read data captured for port 0's last read.
- m1_req, m1_we, m1_addr, m1_wd, m1_funct3, m1_gnt, m1_ack, m1_err, m1_rdata: identical to the m0_* set, for port 1.
- mem_we  out  1  dmem write enable.
- mem_addr  out  32  dmem address.
- mem_wd  out  32  dmem write data.
- mem_funct3  out  3  dmem funct3.
- mem_rd  in  32  dmem combinational read data.

Behaviour:
- State:
  - owner (1 bit): last port granted.
  - cnt (4 bits): consecutive beats granted to owner.
  - ack, err and rdata registers per port.
- Reset values: owner=0, cnt=0, m*_ack=0, m*_err=0, m*_rdata=0.
- While reset=1: m*_gnt=0 and mem_we=0, regardless of requests. A beat presented in the reset cycle is dropped with no ack.
- Winner selection, evaluated combinationally each cycle:
  - Neither port requests: no grant.
  - Exactly one port requests: that port wins.
  - Both ports request: owner wins if cnt < MAX_BURST, otherwise the other port wins.
- Grant outputs: m*_gnt = that port requests AND is the winner. At most one grant per cycle.
- State update at the clock edge:
  - Grant to owner: cnt <= min(cnt+1, MAX_BURST).
  - Grant to the non-owner: owner <= winner, cnt <= 1.
  - No grant: cnt <= 0, owner unchanged.
- Memory mux:
  - mem_addr, mem_wd and mem_funct3 come from the winner; they come from port owner when there is no grant.
  - mem_we = winner_we AND grant AND (addr < DMEM_LIMIT).
- Out-of-range access:
  - Write: suppressed.
  - Read: rdata <= 0.
  - In both cases m*_err pulses alongside m*_ack.
- Completion, one cycle after a granted beat:
  - The granted port's ack is 1 in the next cycle only.
  - On a read, that port's rdata <= mem_rd (or 0 if out of range).
  - On a write, rdata holds its previous value.
  - The other port's ack stays 0.
- Latency: request to grant is 0 cycles when uncontended; grant to ack/rdata is 1 cycle.
- Back-to-back beats from one port produce back-to-back ack pulses.
- A requester holds req, addr, wd, we and funct3 stable until it sees gnt.
- Burst limit:
  - With continuous contention, ports alternate in bursts of exactly MAX_BURST beats.
  - With MAX_BURST=1, ports alternate every beat.
- cnt saturates at MAX_BURST when only the owner requests, so a waiting port wins on its first contended cycle after a long solo burst.

Test Plan:
- Reset, then m0 reads 0x100 with mem_rd=32'hDEADBEEF -> m0_gnt=1 in the same cycle; next cycle m0_ack=1, m0_rdata=32'hDEADBEEF, m1_ack=0.
- m0 and m1 both hold req for 12 cycles from reset with MAX_BURST=4 -> grant sequence m0×4, m1×4, m0×4; exactly one gnt per cycle.
- m1 alone writes 6 beats, then m0 and m1 both request -> m0 wins on the first contended cycle (cnt saturated at 4).
- m0 writes 0x3000 with wd=1 -> mem_we=0; next cycle m0_ack=1, m0_err=1; a read of 0x3004 returns m0_rdata=0 with err=1.
- Assert reset while both ports are requesting mid-burst -> gnt=0 and mem_we=0 during reset; after release owner=0, cnt=0, and m0 wins first.
- m0 writes 0x200=32'h12345678, then reads it back through a dmem model -> m0_rdata=32'h12345678 one cycle after the read grant; m0_rdata is unchanged after the write ack.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the processor
// data port (m0) and the loader/DMA port (m1).
//
// One memory beat per clock. Arbitration is sticky round-robin: the port that
// won last keeps winning under contention until it has taken MAX_BURST
// consecutive beats, then the other port gets a turn. Read data and the
// acknowledge are registered, so a beat granted in cycle N completes in N+1.
//
// Ports
//   clk, reset                  core clock, synchronous active-high reset
//   m{0,1}_req/we/addr/wd/funct3  beat request from each requester
//   m{0,1}_gnt                  beat accepted this cycle (combinational)
//   m{0,1}_ack/err              completion pulse (+ out-of-range flag)
//   m{0,1}_rdata                data of that port's last completed read
//   mem_we/addr/wd/funct3       to dmem
//   mem_rd                      dmem combinational read data
module dmem_arbiter #(
    parameter int          MAX_BURST  = 4,
    parameter logic [31:0] DMEM_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic [2:0]  m0_funct3,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic [2:0]  m1_funct3,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rd
);

    localparam logic [3:0] BURST = 4'(MAX_BURST);

    logic       owner;
    logic [3:0] cnt;

    logic winner;
    logic grant;
    logic sel_we;
    logic in_range;

    // Winner selection. With no request the winner defaults to the owner so
    // the memory-side mux stays parked on the last granted port.
    always_comb begin
        winner = owner;
        if (m0_req && m1_req)
            winner = (cnt < BURST) ? owner : ~owner;
        else if (m0_req)
            winner = 1'b0;
        else if (m1_req)
            winner = 1'b1;

        grant = (m0_req | m1_req) & ~reset;

        if (winner) begin
            sel_we     = m1_we;
            mem_addr   = m1_addr;
            mem_wd     = m1_wd;
            mem_funct3 = m1_funct3;
        end else begin
            sel_we     = m0_we;
            mem_addr   = m0_addr;
            mem_wd     = m0_wd;
            mem_funct3 = m0_funct3;
        end

        in_range = (mem_addr < DMEM_LIMIT);
        m0_gnt   = grant & ~winner;
        m1_gnt   = grant &  winner;
        mem_we   = grant & sel_we & in_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= 1'b0;
            cnt      <= 4'd0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= 32'd0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= 32'd0;
        end else begin
            m0_ack <= m0_gnt;
            m1_ack <= m1_gnt;
            m0_err <= m0_gnt & ~in_range;
            m1_err <= m1_gnt & ~in_range;

            // Writes leave rdata untouched; out-of-range reads return zero.
            if (m0_gnt && !sel_we)
                m0_rdata <= in_range ? mem_rd : 32'd0;
            if (m1_gnt && !sel_we)
                m1_rdata <= in_range ? mem_rd : 32'd0;

            // cnt saturates so a long solo burst lets the waiting port in on
            // its very first contended cycle.
            if (grant) begin
                if (winner == owner) begin
                    cnt <= (cnt >= BURST) ? BURST : cnt + 4'd1;
                end else begin
                    owner <= winner;
                    cnt   <= 4'd1;
                end
            end else begin
                cnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic [2:0]  m0_funct3, m1_funct3;
    logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [2:0]  mem_funct3;

    int n_cmp = 0;
    int n_bad = 0;

    // dmem model: 4K words, filled with a known pattern while init_req is high
    logic [31:0] mem [0:4095];
    logic        init_req;
    logic        use_override;
    logic [31:0] rd_override;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (mem_we) begin
            mem[mem_addr[13:2]] <= mem_wd;
        end
    end

    assign mem_rd = use_override ? rd_override : mem[mem_addr[13:2]];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(MB), .DMEM_LIMIT(32'h0000_3000)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_funct3(m1_funct3), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wd = wd; m0_funct3 = 3'd2;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wd = wd; m1_funct3 = 3'd2;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; init_req = 1'b1; use_override = 1'b0; rd_override = 32'h0;
        drive0(1'b1, 1'b1, 32'h900, 32'h1111_1111);
        drive1(1'b1, 1'b1, 32'h904, 32'h2222_2222);
        #1;
        n_cmp++; if (m0_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt0: got %b want 0", m0_gnt); end
        n_cmp++; if (m1_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt1: got %b want 0", m1_gnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        tick();
        init_req = 1'b0;
        tick();
        n_cmp++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin n_bad++; $display("FAIL rst_ack_err: got %b want 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
        n_cmp++; if (m0_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata0: got %h want 0", m0_rdata); end
        n_cmp++; if (m1_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata1: got %h want 0", m1_rdata); end
        idle();
        reset = 1'b0;
        tick();
        n_cmp++; if ({m0_ack, m1_ack} !== 2'b00) begin n_bad++; $display("FAIL rst_dropped_ack: got %b want 00", {m0_ack, m1_ack}); end
    endtask

    task automatic test_single_read();
        use_override = 1'b1; rd_override = 32'hDEAD_BEEF;
        drive0(1'b1, 1'b0, 32'h100, 32'h0);
        #1;
        n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL rd_gnt0: got %b want 1", m0_gnt); end
        n_cmp++; if (m1_gnt !== 1'b0) begin n_bad++; $display("FAIL rd_gnt1: got %b want 0", m1_gnt); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL rd_addr: got %h want 100", mem_addr); end
        tick();
        idle();
        rd_override = 32'h0;
        n_cmp++; if (m0_ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack0: got %b want 1", m0_ack); end
        n_cmp++; if (m0_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data0: got %h want deadbeef", m0_rdata); end
        n_cmp++; if (m1_ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack1: got %b want 0", m1_ack); end
        n_cmp++; if (m0_err !== 1'b0) begin n_bad++; $display("FAIL rd_err0: got %b want 0", m0_err); end
        tick();
        use_override = 1'b0;
        n_cmp++; if (m0_ack !== 1'b0) begin n_bad++; $display("FAIL rd_ack_pulse: got %b want 0", m0_ack); end
    endtask

    task automatic test_contention();
        do_reset();
        drive0(1'b1, 1'b0, 32'h140, 32'h0);
        drive1(1'b1, 1'b0, 32'h180, 32'h0);
        for (int i = 0; i < 12; i++) begin
            logic want0;
            want0 = ((i / MB) % 2) == 0;
            #1;
            n_cmp++; if (m0_gnt !== want0 || m1_gnt !== !want0) begin n_bad++; $display("FAIL burst_seq cycle %0d: got gnt0=%b gnt1=%b want gnt0=%b", i, m0_gnt, m1_gnt, want0); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive1(1'b1, 1'b1, 32'h800 + 32'(4 * i), 32'h5500_0000 + 32'(i));
            #1;
            n_cmp++; if (m1_gnt !== 1'b1) begin n_bad++; $display("FAIL solo_gnt1 beat %0d: got %b want 1", i, m1_gnt); end
            tick();
        end
        drive0(1'b1, 1'b0, 32'h804, 32'h0);
        drive1(1'b1, 1'b1, 32'h818, 32'h5500_0006);
        #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL sat_first_contend: got gnt0,gnt1=%b want 10", {m0_gnt, m1_gnt}); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_out_of_range();
        drive0(1'b1, 1'b1, 32'h3000, 32'h1);
        #1;
        n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL oor_gnt: got %b want 1", m0_gnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL oor_mem_we: got %b want 0", mem_we); end
        tick();
        n_cmp++; if ({m0_ack, m0_err} !== 2'b11) begin n_bad++; $display("FAIL oor_wr_ack_err: got %b want 11", {m0_ack, m0_err}); end
        use_override = 1'b1; rd_override = 32'hFFFF_FFFF;
        drive0(1'b1, 1'b0, 32'h3004, 32'h0);
        tick();
        idle();
        use_override = 1'b0;
        n_cmp++; if ({m0_ack, m0_err} !== 2'b11) begin n_bad++; $display("FAIL oor_rd_ack_err: got %b want 11", {m0_ack, m0_err}); end
        n_cmp++; if (m0_rdata !== 32'h0) begin n_bad++; $display("FAIL oor_rdata: got %h want 0", m0_rdata); end
        tick();
        n_cmp++; if (m0_err !== 1'b0) begin n_bad++; $display("FAIL oor_err_pulse: got %b want 0", m0_err); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive0(1'b1, 1'b1, 32'h900, 32'hAAAA_0000);
        drive1(1'b1, 1'b1, 32'h904, 32'hBBBB_0000);
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_bad++; $display("FAIL midrst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL midrst_mem_we: got %b want 0", mem_we); end
        tick();
        reset = 1'b0;
        n_cmp++; if ({m0_ack, m1_ack} !== 2'b00) begin n_bad++; $display("FAIL midrst_ack: got %b want 00", {m0_ack, m1_ack}); end
        // fresh owner=0/cnt=0: m0 takes a full burst of MB, then m1
        for (int i = 0; i <= MB; i++) begin
            logic want0;
            want0 = (i < MB);
            #1;
            n_cmp++; if (m0_gnt !== want0 || m1_gnt !== !want0) begin n_bad++; $display("FAIL midrst_seq %0d: got gnt0=%b gnt1=%b want gnt0=%b", i, m0_gnt, m1_gnt, want0); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_write_readback();
        drive0(1'b1, 1'b0, 32'h204, 32'h0);
        tick();
        n_cmp++; if (m0_rdata !== pat(32'h204 >> 2)) begin n_bad++; $display("FAIL wrb_pre_read: got %h want %h", m0_rdata, pat(32'h204 >> 2)); end
        drive0(1'b1, 1'b1, 32'h200, 32'h1234_5678);
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL wrb_mem_we: got %b want 1", mem_we); end
        tick();
        n_cmp++; if (m0_ack !== 1'b1) begin n_bad++; $display("FAIL wrb_wr_ack: got %b want 1", m0_ack); end
        n_cmp++; if (m0_rdata !== pat(32'h204 >> 2)) begin n_bad++; $display("FAIL wrb_rdata_hold: got %h want %h", m0_rdata, pat(32'h204 >> 2)); end
        drive0(1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        idle();
        n_cmp++; if (m0_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL wrb_readback: got %h want 12345678", m0_rdata); end
        tick();
    endtask

    // Random traffic against a transaction-level reference: a shared word
    // array, per-port expected rdata, and a run-length count of consecutive
    // beats for the current holder of the bus.
    task automatic test_random();
        logic        q_req [2];
        logic        q_we  [2];
        logic [31:0] q_addr[2];
        logic [31:0] q_wd  [2];
        logic [2:0]  q_f3  [2];
        logic        pend  [2];
        logic [31:0] e_rd  [2];
        logic [31:0] ref_mem [0:4095];
        logic        e_ack [2];
        logic        e_err [2];
        int own, run, w;

        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        do_reset();
        own = 0; run = 0;
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; e_rd[p] = 32'h0; end

        for (int c = 0; c < 400; c++) begin
            logic oor, wr;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    q_req[p]  = ($urandom_range(0, 9) < 6);
                    q_we[p]   = 1'($urandom_range(0, 1));
                    q_addr[p] = ($urandom_range(0, 7) == 0) ? 32'h3000 + 32'(4 * $urandom_range(0, 255))
                                                             : 32'h400 + 32'(4 * $urandom_range(0, 63));
                    q_wd[p]   = $urandom;
                    q_f3[p]   = 3'($urandom_range(0, 7));
                end
            end
            m0_req = q_req[0]; m0_we = q_we[0]; m0_addr = q_addr[0]; m0_wd = q_wd[0]; m0_funct3 = q_f3[0];
            m1_req = q_req[1]; m1_we = q_we[1]; m1_addr = q_addr[1]; m1_wd = q_wd[1]; m1_funct3 = q_f3[1];
            #1;
            if (q_req[0] && q_req[1]) w = (run < MB) ? own : 1 - own;
            else if (q_req[0])        w = 0;
            else if (q_req[1])        w = 1;
            else                      w = -1;

            n_cmp++; if (m0_gnt !== (w == 0) || m1_gnt !== (w == 1)) begin n_bad++; $display("FAIL rnd_gnt cyc %0d: got %b%b want winner %0d", c, m0_gnt, m1_gnt, w); end
            oor = 1'b0; wr = 1'b0;
            if (w >= 0) begin
                oor = (q_addr[w] >= 32'h3000);
                wr  = q_we[w];
                n_cmp++; if (mem_addr !== q_addr[w] || mem_wd !== q_wd[w] || mem_funct3 !== q_f3[w]) begin n_bad++; $display("FAIL rnd_mux cyc %0d: got %h/%h/%0d want %h/%h/%0d", c, mem_addr, mem_wd, mem_funct3, q_addr[w], q_wd[w], q_f3[w]); end
            end
            n_cmp++; if (mem_we !== (w >= 0 && wr && !oor)) begin n_bad++; $display("FAIL rnd_mem_we cyc %0d: got %b want %b", c, mem_we, (w >= 0 && wr && !oor)); end

            for (int p = 0; p < 2; p++) begin
                e_ack[p] = (w == p);
                e_err[p] = (w == p) && oor;
                if (w == p && !wr) e_rd[p] = oor ? 32'h0 : ref_mem[q_addr[p][13:2]];
                pend[p] = q_req[p] && (w != p);
            end
            if (w >= 0 && wr && !oor) ref_mem[q_addr[w][13:2]] = q_wd[w];

            if (w < 0)          run = 0;
            else if (w == own)  run = (run + 1 > MB) ? MB : run + 1;
            else begin own = w; run = 1; end

            tick();
            n_cmp++; if (m0_ack !== e_ack[0] || m0_err !== e_err[0] || m0_rdata !== e_rd[0]) begin n_bad++; $display("FAIL rnd_p0 cyc %0d: got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h", c, m0_ack, m0_err, m0_rdata, e_ack[0], e_err[0], e_rd[0]); end
            n_cmp++; if (m1_ack !== e_ack[1] || m1_err !== e_err[1] || m1_rdata !== e_rd[1]) begin n_bad++; $display("FAIL rnd_p1 cyc %0d: got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h", c, m1_ack, m1_err, m1_rdata, e_ack[1], e_err[1], e_rd[1]); end
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_contention();
        test_saturation();
        test_out_of_range();
        test_reset_mid_burst();
        test_write_readback();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
